// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: TXD/CON registers, small transmit FIFO,
// 8N1 serializer with a baud counter, and a transmit-done interrupt.
module uart_tx_periph #(
  parameter int unsigned BAUD_DIV   = 5208,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  localparam logic [31:0] ADDR_TXD = 32'h4000_000C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [PW:0] FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

  logic [1:0]    state_q, state_d;
  logic          tx_q, tx_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic [15:0]   baud_q, baud_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ie_q, ie_d, done_q, done_d, ovf_q, ovf_d;
  logic [7:0]    last_q, last_d;

  logic wr_txd, wr_con, pop, push_ok, push_drop, done_set, baud_end, busy;
  logic unused_wdata;

  assign unused_wdata = ^WriteData[31:8];

  always_comb begin
    wr_txd    = MemWrite && (Addr == ADDR_TXD);
    wr_con    = MemWrite && (Addr == ADDR_CON);
    pop       = (state_q == S_IDLE) && (count_q != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    push_ok   = wr_txd && ((count_q != FIFO_FULL) || pop);
    push_drop = wr_txd && !push_ok;
    busy      = (state_q != S_IDLE) || (count_q != '0);
  end

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    done_set = 1'b0;
    baud_end = (baud_q == BAUD_LAST);
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (pop) begin
          state_d = S_START;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            // tx is registered, so it takes the bit that will sit in shift[0] next.
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        if (baud_end) begin
          state_d  = S_IDLE;
          baud_d   = '0;
          tx_d     = 1'b1;
          done_set = 1'b1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ie_d   = ie_q;
    done_d = done_q;
    ovf_d  = ovf_q;
    last_d = last_q;
    if (wr_con) begin
      ie_d = WriteData[0];
      if (WriteData[2]) done_d = 1'b0;
      if (WriteData[3]) ovf_d  = 1'b0;
    end
    if (done_set)  done_d = 1'b1;
    if (push_drop) ovf_d  = 1'b1;
    if (push_ok)   last_d = WriteData[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      shift_q  <= '0;
      bit_q    <= '0;
      baud_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ie_q     <= ie_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= WriteData[7:0];
  end

  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      if (Addr == ADDR_CON)      ReadData = {27'b0, busy, ovf_q, done_q, 1'b0, ie_q};
      else if (Addr == ADDR_TXD) ReadData = {24'b0, last_q};
    end
  end

  assign tx  = tx_q;
  assign irq = ie_q & done_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: directed register/frame scenarios plus random bursts,
// with a serial-line receiver reconstructing bytes and frame timing.
module tb_uart_tx_periph;

  localparam int unsigned BD    = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] TXD = 32'h4000_000C;
  localparam logic [31:0] CON = 32'h4000_0020;
  localparam logic [31:0] BAD = 32'h4000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        tx;
  logic        irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  bit         rx_ok[$];
  int         rx_start[$];
  logic [7:0] exp_q[$];
  logic [7:0] bq[$];

  uart_tx_periph #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line receiver: a frame is 1 start, 8 data (LSB first), 1 stop bit, each BD cycles.
  initial begin : rx_mon
    logic [7:0] v;
    bit ok, aborted;
    int s;
    forever begin
      @(posedge clk); #1;
      if (!reset && tx === 1'b0) begin
        v = '0; ok = 1'b1; aborted = 1'b0; s = cyc;
        for (int i = 1; i < BD; i++) begin
          @(posedge clk); #1;
          aborted |= reset;
          if (tx !== 1'b0) ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
          for (int j = 0; j < BD; j++) begin
            @(posedge clk); #1;
            aborted |= reset;
            if (j == 0) v[b] = tx;
            else if (tx !== v[b]) ok = 1'b0;
          end
        end
        for (int j = 0; j < BD; j++) begin
          @(posedge clk); #1;
          aborted |= reset;
          if (tx !== 1'b1) ok = 1'b0;
        end
        if (!aborted) begin
          rx_q.push_back(v);
          rx_ok.push_back(ok);
          rx_start.push_back(s);
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite = 1'b1; Addr = a; WriteData = d;
    @(negedge clk);
    MemWrite = 1'b0; Addr = '0; WriteData = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    MemRead = 1'b1; Addr = a;
    #1 d = ReadData;
    MemRead = 1'b0; Addr = '0;
  endtask

  // Back-to-back TXD writes of bq[], one per cycle, with random upper data bits.
  task automatic burst();
    logic [31:0] r32;
    for (int i = 0; i < bq.size(); i++) begin
      @(negedge clk);
      r32 = $urandom;
      MemWrite = 1'b1; Addr = TXD; WriteData = {r32[31:8], bq[i]};
    end
    @(negedge clk);
    MemWrite = 1'b0; Addr = '0; WriteData = '0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] r;
    int n;
    n = 0;
    do begin
      rd(CON, r);
      n++;
    end while (r[4] && n < 2000);
    check({tag, "_idle"}, {31'b0, r[4]}, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_nframes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check({tag, "_byte"}, {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
      check({tag, "_frame"}, {31'b0, rx_ok[i]}, 32'h1);
    end
    rx_q.delete(); rx_ok.delete(); rx_start.delete(); exp_q.delete();
  endtask

  initial begin : watchdog
    #600000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] r;
    logic [31:0] a;
    logic [7:0]  fb;
    logic        exp_tx;
    int          n0, n;

    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rd(CON, r); check("rst_con_during", r, 32'h0);
    @(negedge clk); reset = 1'b0;
    rd(CON, r); check("rst_con", r, 32'h0);
    rd(TXD, r); check("rst_txd", r, 32'h0);
    check("rst_tx_after", {31'b0, tx}, 32'h1);

    // Single frame, cycle-exact waveform of 0x41
    fb = 8'h41;
    wr(TXD, 32'hABCD_EF41); n0 = cyc; exp_q.push_back(fb);
    for (int k = 1; k <= 10 * BD + 1; k++) begin
      @(posedge clk); #1;
      if (k <= BD)           exp_tx = 1'b0;
      else if (k <= 9 * BD)  exp_tx = fb[(k - BD - 1) / BD];
      else                   exp_tx = 1'b1;
      check("t1_tx", {31'b0, tx}, {31'b0, exp_tx});
      if (k >= 10 * BD) begin
        rd(CON, r);
        check("t1_con", r, (k == 10 * BD + 1) ? 32'h4 : 32'h10);
      end
    end
    check("t1_n0", cyc - n0 >= 10 * BD + 1 ? 32'h1 : 32'h0, 32'h1);
    rd(TXD, r); check("t1_txd", r, 32'h41);
    wait_idle("t1");
    check_rx("t1");
    wr(CON, 32'h4);

    // Interrupt: irq follows done while ie=1, cleared by W1C
    wr(CON, 32'h1);
    rd(CON, r); check("t2_ie", r, 32'h1);
    fb = 8'($urandom);
    wr(TXD, {24'b0, fb}); exp_q.push_back(fb);
    check("t2_irq_low", {31'b0, irq}, 32'h0);
    n = 0;
    while (irq !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("t2_irq_rise", {31'b0, irq}, 32'h1);
    rd(CON, r); check("t2_con_done", r, 32'h5);
    wr(CON, 32'h4);
    check("t2_irq_clr", {31'b0, irq}, 32'h0);
    rd(CON, r); check("t2_con_clr", r, 32'h0);
    repeat (3) @(negedge clk);
    check_rx("t2");

    // Overflow: six back-to-back writes while idle
    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back(8'(8'h10 + i));
    burst();
    for (int i = 0; i < 5; i++) exp_q.push_back(bq[i]);
    rd(CON, r); check("t3_con_ovf", r, 32'h18);
    wait_idle("t3");
    for (int i = 1; i < rx_start.size(); i++)
      check("t3_gap", rx_start[i] - rx_start[i - 1] - 10 * BD, 32'h1);
    check_rx("t3");
    rd(CON, r); check("t3_con_end", r, 32'hC);
    wr(CON, 32'hC);
    rd(CON, r); check("t3_con_w1c", r, 32'h0);

    // Push into a full FIFO on the same edge as a pop
    bq.delete();
    for (int i = 0; i < 5; i++) bq.push_back(8'($urandom));
    burst();
    n0 = cyc - 4;
    foreach (bq[i]) exp_q.push_back(bq[i]);
    while (cyc < n0 + 10 * BD) @(negedge clk);
    fb = 8'($urandom);
    wr(TXD, {24'b0, fb}); exp_q.push_back(fb);
    rd(CON, r); check("t4_con", r, 32'h14);
    wait_idle("t4");
    check_rx("t4");
    rd(CON, r); check("t4_con_end", r, 32'h4);
    wr(CON, 32'hC);

    // Reset during the data phase of 0x55
    wr(TXD, 32'h55); n0 = cyc;
    while (cyc < n0 + 10) @(negedge clk);
    check("t5_pre_tx", {31'b0, tx}, 32'h0);
    reset = 1'b1;
    #1;
    check("t5_async_tx", {31'b0, tx}, 32'h1);
    check("t5_irq", {31'b0, irq}, 32'h0);
    MemRead = 1'b1; Addr = CON;
    #1 check("t5_rd_in_rst", ReadData, 32'h0);
    MemRead = 1'b0; Addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(CON, r); check("t5_con_after", r, 32'h0);
    repeat (12 * BD) @(negedge clk);
    check("t5_tx_idle", {31'b0, tx}, 32'h1);
    rd(CON, r); check("t5_no_done", r, 32'h0);
    rx_q.delete(); rx_ok.delete(); rx_start.delete(); exp_q.delete();
    wr(TXD, 32'hAA); exp_q.push_back(8'hAA);
    wait_idle("t5");
    check_rx("t5");
    wr(CON, 32'h4);

    // Undecoded address and MemRead low
    rd(BAD, r); check("t6_bad_rd", r, 32'h0);
    @(negedge clk);
    Addr = CON; MemRead = 1'b0;
    #1 check("t6_noread_con", ReadData, 32'h0);
    Addr = TXD;
    #1 check("t6_noread_txd", ReadData, 32'h0);
    Addr = '0;
    wr(BAD, 32'h41);
    repeat (20) @(negedge clk);
    check("t6_noframe", rx_q.size(), 32'h0);
    rd(CON, r); check("t6_con", r, 32'h0);
    rd(TXD, r); check("t6_txd", r, 32'hAA);

    // Random bursts that fit in FIFO plus the shift register
    for (int it = 0; it < 20; it++) begin
      bq.delete();
      n = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      burst();
      foreach (bq[i]) exp_q.push_back(bq[i]);
      a = 32'h4000_0000 + 32'($urandom_range(0, 15)) * 4;
      if (a != TXD && a != CON) begin
        rd(a, r); check("rnd_bad_rd", r, 32'h0);
      end
      wait_idle("rnd");
      rd(TXD, r); check("rnd_txd", r, {24'b0, bq[n - 1]});
      rd(CON, r); check("rnd_con", r, 32'h4);
      check_rx("rnd");
      wr(CON, 32'h4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 5208, giving clock cycles per serial bit (50 MHz / 9600); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving transmit FIFO entries (power of two).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port MemRead  input  1  CPU load strobe.
REQ-006 SHALL have port MemWrite  input  1  CPU store strobe.
REQ-007 SHALL have port Addr  input  32  CPU byte address.
REQ-008 SHALL have port WriteData  input  32  CPU store data.
REQ-009 SHALL have port ReadData  output  32  register read data, combinational.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port irq  output  1  transmit-done interrupt request.

Function
REQ-012 SHALL decode 0x4000000C as UART_TXD and 0x40000020 as UART_CON; all other addresses are ignored on write and read 0.
REQ-013 SHALL, on MemWrite to UART_TXD, push WriteData[7:0] into the FIFO; bits [31:8] are ignored.
REQ-014 SHALL, on a push while the FIFO is full with no pop in the same cycle, drop the byte and set CON.ovf (bit 3).
REQ-015 SHALL accept the push when the FIFO is full and a pop occurs in the same cycle; count is unchanged.
REQ-016 SHALL, on MemWrite to UART_CON, write bit 0 to CON.ie; bits 2 and 3 are write-1-to-clear; other bits are ignored.
REQ-017 SHALL return, for MemRead at UART_CON, ReadData = {27'b0, busy, ovf, done, 1'b0, ie}, where busy (bit 4) = state != IDLE or FIFO not empty.
REQ-018 SHALL return, for MemRead at UART_TXD, ReadData = {24'b0, last byte pushed}.
REQ-019 SHALL return ReadData = 0 when MemRead is low.
REQ-020 SHALL implement the FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-021 SHALL, in IDLE with the FIFO not empty, pop the head byte into the shift register and enter START on the same edge.
REQ-022 SHALL drive tx registered: 1 in IDLE, 0 in START, shift[0] in DATA (LSB first, 8 bits), and 1 in STOP.
REQ-023 SHALL hold each of START, each DATA bit, and STOP for exactly BAUD_DIV cycles, timed by a baud counter cleared on every state or bit change.
REQ-024 SHALL, on leaving STOP, enter IDLE and set CON.done (bit 2) on the same edge.
REQ-025 SHALL leave a minimum of one IDLE cycle (tx=1) between back-to-back frames.
REQ-026 SHALL make set take priority over clear when a done set and a done W1C occur in the same cycle.
REQ-027 SHALL keep irq = ie & done combinational.
REQ-028 SHALL make the FIFO read/write pointers wrap modulo FIFO_DEPTH, with count held in log2(FIFO_DEPTH)+1 bits.

Reset
REQ-029 SHALL, while reset is high and regardless of clk, force state=IDLE, tx=1, FIFO empty, pointers=0, baud counter=0, ie=0, done=0, ovf=0, last byte=0; irq and ReadData follow as 0.
REQ-030 SHALL abort a frame in progress immediately on reset (tx returns to 1 without completing the stop bit), and SHALL NOT set done.

Verification
REQ-031 SHALL cover, with BAUD_DIV=4: write 0x41 to UART_TXD at edge N -> tx=0 during cycles N+1..N+4, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, stop=1 for 4 cycles, done=1 at edge N+41.
REQ-032 SHALL cover: CON.ie=1, send one byte -> irq rises with done; write 0x4 to UART_CON -> irq=0 next cycle; CON read shows busy=0.
REQ-033 SHALL cover: 6 back-to-back writes 0x10..0x15 while idle -> first popped immediately, FIFO holds 4, sixth dropped, ovf=1; line carries 0x10..0x14 only, each frame separated by exactly one idle cycle.
REQ-034 SHALL cover: push when full in the same cycle as a pop -> byte accepted, ovf stays 0.
REQ-035 SHALL cover: reset asserted mid-DATA of byte 0x55 -> tx=1 asynchronously, FIFO empty, done=0; after release, a new write 0xAA transmits a correct frame.
REQ-036 SHALL cover: reads at 0x40000010 and with MemRead=0 -> ReadData=0; write to 0x40000010 -> no frame produced.
